// File: rtl/verify_loader.sv
// Verify-transaction loader: splits the host word stream into tagged signature
// fields for the verify core, then returns the core's accept/reject verdict.
module verify_loader #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   sec_lvl,
   input  logic         valid_i,
   output logic         ready_i,
   input  logic [W-1:0] data_i,
   output logic         fo_valid,
   input  logic         fo_ready,
   output logic [W-1:0] fo_data,
   output logic [2:0]   fo_field,
   output logic [15:0]  fo_idx,
   output logic         fo_last,
   input  logic         res_valid_i,
   input  logic         res_reject_i,
   output logic         res_ready_o,
   output logic         valid_o,
   input  logic         ready_o,
   output logic [W-1:0] data_o,
   output logic         busy,
   output logic         err
);

   localparam int BPW = W / 8;
   localparam logic [15:0] N_RHO = 16'((256 + W - 1) / W);
   localparam logic [15:0] N_C   = 16'((256 + W - 1) / W);
   localparam logic [15:0] N_Z2  = 16'((18432 + W - 1) / W);
   localparam logic [15:0] N_Z3  = 16'((25600 + W - 1) / W);
   localparam logic [15:0] N_Z5  = 16'((35840 + W - 1) / W);
   localparam logic [15:0] N_T2  = 16'((10240 + W - 1) / W);
   localparam logic [15:0] N_T3  = 16'((15360 + W - 1) / W);
   localparam logic [15:0] N_T5  = 16'((20480 + W - 1) / W);
   localparam logic [15:0] N_H2  = 16'((704 + W - 1) / W);
   localparam logic [15:0] N_H3  = 16'((512 + W - 1) / W);
   localparam logic [15:0] N_H5  = 16'((704 + W - 1) / W);

   typedef enum logic [3:0] {
      IDLE, RHO, C, Z, T1, MLEN, MSG, H, WAIT_RES, OUT_RES
   } state_t;

   state_t      state;
   logic [2:0]  lvl;
   logic [15:0] cnt;
   logic [15:0] mlen;
   logic        reject;
   logic [15:0] n_words;
   logic [15:0] msg_words;
   logic        load;
   logic        fo_free;
   logic        acc;
   logic        last_word;

   function automatic logic legal_lvl(input logic [2:0] l);
      return (l == 3'b010) || (l == 3'b011) || (l == 3'b101);
   endfunction

   function automatic logic [2:0] field_tag(input state_t s);
      case (s)
         C:       return 3'd1;
         Z:       return 3'd2;
         T1:      return 3'd3;
         MLEN:    return 3'd4;
         MSG:     return 3'd5;
         H:       return 3'd6;
         default: return 3'd0;
      endcase
   endfunction

   function automatic state_t next_field(input state_t s, input logic zero_len);
      case (s)
         RHO:     return C;
         C:       return Z;
         Z:       return T1;
         T1:      return MLEN;
         MLEN:    return zero_len ? H : MSG;
         MSG:     return H;
         default: return s;
      endcase
   endfunction

   // MSG length in words: ceil(mlen bytes / bytes per word)
   assign msg_words = 16'((int'(mlen) + BPW - 1) / BPW);

   always_comb begin
      n_words = 16'd1;
      case (state)
         RHO:  n_words = N_RHO;
         C:    n_words = N_C;
         Z: begin
            case (lvl)
               3'b011:  n_words = N_Z3;
               3'b101:  n_words = N_Z5;
               default: n_words = N_Z2;
            endcase
         end
         T1: begin
            case (lvl)
               3'b011:  n_words = N_T3;
               3'b101:  n_words = N_T5;
               default: n_words = N_T2;
            endcase
         end
         MSG:  n_words = msg_words;
         H: begin
            case (lvl)
               3'b011:  n_words = N_H3;
               3'b101:  n_words = N_H5;
               default: n_words = N_H2;
            endcase
         end
         default: n_words = 16'd1;
      endcase
   end

   // In H the counter parks at n_words once every word is taken, closing the input
   assign load      = (state inside {RHO, C, Z, T1, MLEN, MSG}) ||
                      ((state == H) && (cnt != n_words));
   assign fo_free   = !fo_valid || fo_ready;
   assign ready_i   = load && fo_free;
   assign acc       = valid_i && ready_i;
   assign last_word = (cnt == n_words - 16'd1);

   assign busy        = (state != IDLE);
   assign res_ready_o = (state == WAIT_RES);
   assign valid_o     = (state == OUT_RES);
   assign data_o      = {{(W-1){1'b0}}, reject};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lvl      <= 3'd0;
         cnt      <= 16'd0;
         mlen     <= 16'd0;
         reject   <= 1'b0;
         err      <= 1'b0;
         fo_valid <= 1'b0;
         fo_data  <= '0;
         fo_field <= 3'd0;
         fo_idx   <= 16'd0;
         fo_last  <= 1'b0;
      end else begin
         if (acc) begin
            fo_valid <= 1'b1;
            fo_data  <= data_i;
            fo_field <= field_tag(state);
            fo_idx   <= cnt;
            fo_last  <= last_word;
         end else if (fo_ready) begin
            fo_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (legal_lvl(sec_lvl)) begin
                     state <= RHO;
                     lvl   <= sec_lvl;
                     err   <= 1'b0;
                     cnt   <= 16'd0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            H: begin
               if (cnt == n_words) begin
                  if (fo_free) begin
                     state <= WAIT_RES;
                     cnt   <= 16'd0;
                  end
               end else if (acc) begin
                  cnt <= cnt + 16'd1;
               end
            end
            WAIT_RES: begin
               if (res_valid_i) begin
                  reject <= res_reject_i;
                  state  <= OUT_RES;
               end
            end
            OUT_RES: begin
               if (ready_o) state <= IDLE;
            end
            default: begin
               if (acc) begin
                  if (state == MLEN) mlen <= data_i[15:0];
                  if (last_word) begin
                     cnt   <= 16'd0;
                     state <= next_field(state, data_i[15:0] == 16'd0);
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: doc/verify_loader.md
VERIFY_LOADER -- requirements
Module: verify_loader

Interface
REQ-001 Parameter W, default 64, host/core stream word width in bits (multiple of 8, ≥32).
REQ-002 Port clk  in  1  rising-edge clock, single domain.
REQ-003 Port rst_n  in  1  asynchronous active-low reset.
REQ-004 Port start  in  1  one-cycle pulse, begins a verify transaction.
REQ-005 Port sec_lvl  in  3  3'b010/011/101 = level 2/3/5, sampled on start.
REQ-006 Ports valid_i in 1, ready_i out 1, data_i in W: host input stream.
REQ-007 Ports fo_valid out 1, fo_ready in 1, fo_data out W: tagged stream to the verify core.
REQ-008 Port fo_field  out  3  field tag: 0 RHO, 1 C, 2 Z, 3 T1, 4 MLEN, 5 MSG, 6 H.
REQ-009 Port fo_idx  out  16  word index within the field; fo_last  out  1  last word of the field.
REQ-010 Ports res_valid_i in 1, res_reject_i in 1, res_ready_o out 1: verdict from core.
REQ-011 Ports valid_o out 1, ready_o in 1, data_o out W: verdict to host.
REQ-012 Ports busy out 1 (FSM not IDLE), err out 1 (sticky, illegal sec_lvl).

Function
REQ-013 FSM states: IDLE, RHO, C, Z, T1, MLEN, MSG, H, WAIT_RES, OUT_RES.
REQ-014 IDLE + start + legal sec_lvl -> RHO, latch sec_lvl, clear err, counter=0; illegal -> stay IDLE, err=1.
REQ-015 start outside IDLE is ignored.
REQ-016 Field word counts: RHO 4, C 4, MLEN 1; Z 288/400/560; T1 160/240/320; H 11/8/11 for lvl 2/3/5 (counts given for W=64; ceil(bits/W) in general).
REQ-017 Field order: RHO, C, Z, T1, MLEN, MSG, H; state advances when the field's last word is accepted.
REQ-018 Input transfer occurs when valid_i && ready_i; ready_i = (load state) && (!fo_valid || fo_ready), combinational.
REQ-019 fo_* is a one-entry output register: accepted word appears on fo_data the next cycle with fo_field, fo_idx = counter, fo_last set; held until fo_ready.
REQ-020 fo_valid deasserts after fo_ready when no new word is accepted in the same cycle; simultaneous drain and accept replaces the entry without a bubble.
REQ-021 MLEN word: data_i[15:0] = message length in bytes, latched; MSG word count = ceil(mlen*8/W); forwarded as field 4.
REQ-022 mlen = 0: MSG skipped, MLEN -> H directly.
REQ-023 Upper MSG-word bytes beyond mlen are forwarded unmodified; the core masks them.
REQ-024 After the H last word is accepted -> WAIT_RES once fo_valid has drained.
REQ-025 WAIT_RES: res_ready_o=1; on res_valid_i latch res_reject_i -> OUT_RES; res_ready_o=0 in all other states.
REQ-026 OUT_RES: valid_o=1, data_o = {(W-1) zeros, reject} (0 accept, 1 reject); on ready_o -> IDLE next cycle.
REQ-027 Gaps: valid_i low for any number of cycles (e.g. 10000) in any load state stalls without state or counter change.
REQ-028 fo_ready low with fo_valid high: ready_i=0, no input is accepted, fo_* stable.

Reset
REQ-029 rst_n low asynchronously forces IDLE, with ready_i, fo_valid, fo_last, res_ready_o, valid_o, busy, err = 0, and fo_data, fo_field, fo_idx, data_o, counter, mlen = 0.
REQ-030 Reset mid-transaction discards all state; the next start begins a fresh RHO field.

Verification
REQ-031 Lvl2 vector, mlen=33, fo_ready=1 constant, core rejects=0 -> 4+4+288+160+1+5+11 = 473 fo words in order, idx restarting per field, data_o=0.
REQ-032 Lvl5, 10000-cycle valid_i gaps before MSG and before H -> identical fo sequence; fo_last exactly on word 3,3,559,319,0,last,10.
REQ-033 Lvl3, mlen=0 -> no MSG words; MLEN word is followed directly by H idx 0; 8 H words.
REQ-034 Random fo_ready backpressure (50%) -> no loss or duplication; at most one word in flight; ready_i low whenever fo_valid && !fo_ready.
REQ-035 Core verdict reject=1 with ready_o held low for 20 cycles -> valid_o=1, data_o=1 stable throughout; IDLE one cycle after ready_o.
REQ-036 sec_lvl=3'b100 with start -> err=1, busy=0, ready_i=0; rst_n pulse during Z -> all outputs 0 immediately.
